// File: rtl/tank_sprite_compositor_if.sv
// Pixel stream, sprite ROM, palette write and RGB/collision bus of the tank compositor.
interface tank_sprite_compositor_if #(
   parameter int unsigned NUM_TANKS   = 2,
   parameter int unsigned NUM_BULLETS = 2,
   parameter int unsigned COORD_W     = 10,
   parameter int unsigned IDX_W       = 4,
   parameter int unsigned ADDR_W      = 16
);
   logic                             pix_valid_in;
   logic [COORD_W-1:0]               DrawX;
   logic [COORD_W-1:0]               DrawY;
   logic                             frame_start;
   logic [1:0]                       mode;
   logic [NUM_TANKS*COORD_W-1:0]     TankX;
   logic [NUM_TANKS*COORD_W-1:0]     TankY;
   logic [NUM_BULLETS*COORD_W-1:0]   BulletX;
   logic [NUM_BULLETS*COORD_W-1:0]   BulletY;
   logic [NUM_BULLETS-1:0]           bullet_active;
   logic [NUM_TANKS*ADDR_W-1:0]      tank_rom_addr;
   logic [NUM_TANKS*IDX_W-1:0]       tank_rom_idx;
   logic                             pal_we;
   logic [IDX_W-1:0]                 pal_waddr;
   logic [23:0]                      pal_wdata;
   logic [7:0]                       Red;
   logic [7:0]                       Green;
   logic [7:0]                       Blue;
   logic                             pix_valid_out;
   logic [NUM_TANKS*NUM_BULLETS-1:0] hit_flags;

   // VGA controller / game logic / ROMs side
   modport master (
      output pix_valid_in, DrawX, DrawY, frame_start, mode, TankX, TankY,
             BulletX, BulletY, bullet_active, tank_rom_idx, pal_we, pal_waddr, pal_wdata,
      input  tank_rom_addr, Red, Green, Blue, pix_valid_out, hit_flags
   );

   // Compositor side
   modport slave (
      input  pix_valid_in, DrawX, DrawY, frame_start, mode, TankX, TankY,
             BulletX, BulletY, bullet_active, tank_rom_idx, pal_we, pal_waddr, pal_wdata,
      output tank_rom_addr, Red, Green, Blue, pix_valid_out, hit_flags
   );
endinterface

// File: rtl/tank_sprite_compositor.sv
// Three-stage pixel compositor: sprite tanks + round bullets over a gradient background,
// with a writable palette and per-frame bullet/tank collision flags.
module tank_sprite_compositor #(
   parameter int unsigned NUM_TANKS   = 2,
   parameter int unsigned NUM_BULLETS = 2,
   parameter int unsigned COORD_W     = 10,
   parameter int unsigned TANK_W      = 70,
   parameter int unsigned TANK_H      = 50,
   parameter int unsigned BULLET_R    = 4,
   parameter int unsigned IDX_W       = 4,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned TRANSP_IDX  = 0
) (
   input logic                     Clk,
   input logic                     Reset,
   tank_sprite_compositor_if.slave bus
);

   localparam int unsigned DW    = COORD_W + 1;
   localparam int unsigned SQW   = 2 * DW + 1;
   localparam int unsigned PAL_N = 1 << IDX_W;
   localparam int unsigned NHIT  = NUM_TANKS * NUM_BULLETS;
   localparam int unsigned CW    = 24;
   localparam logic signed [SQW-1:0] R_SQ = SQW'(BULLET_R * BULLET_R);

   // Signed distance between two unsigned coordinates, one bit wider so it never wraps.
   function automatic logic signed [DW-1:0] sdiff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
      return $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction

   // Stage 1 next-state
   logic [NUM_TANKS-1:0]        in_tank_d;
   logic [NUM_TANKS*ADDR_W-1:0] rom_addr_d;
   logic [NUM_BULLETS-1:0]      bul_d;
   logic signed [DW-1:0]        dx_c;
   logic signed [DW-1:0]        dy_c;
   logic signed [SQW-1:0]       sq_c;

   // Stage 1 registers
   logic                        s1_valid_q, s1_fs_q;
   logic [1:0]                  s1_mode_q;
   logic [6:0]                  s1_xh_q;
   logic [NUM_TANKS-1:0]        s1_in_tank_q;
   logic [NUM_BULLETS-1:0]      s1_bul_q;
   logic [NUM_TANKS*ADDR_W-1:0] rom_addr_q;

   // Stage 2 registers
   logic                        s2_valid_q, s2_fs_q;
   logic [1:0]                  s2_mode_q;
   logic [6:0]                  s2_xh_q;
   logic [NUM_TANKS-1:0]        s2_in_tank_q;
   logic [NUM_BULLETS-1:0]      s2_bul_q;
   logic [NUM_TANKS*IDX_W-1:0]  s2_idx_q;

   // Stage 3 registers
   logic                        s3_valid_q, s3_fs_q;
   logic [1:0]                  s3_mode_q;
   logic [6:0]                  s3_xh_q;
   logic [NUM_TANKS-1:0]        s3_opaque_q;
   logic [NUM_BULLETS-1:0]      s3_bul_q;
   logic [NUM_TANKS*CW-1:0]     s3_col_q;

   // Output stage
   logic [CW-1:0]               rgb_d, rgb_q;
   logic [7:0]                  bg_c;
   logic [NHIT-1:0]             hits_d;
   logic                        pix_valid_q;
   logic [NHIT-1:0]             acc_q, hit_q;

   logic [CW-1:0]               pal_q [PAL_N];

   // Stage 1: sprite window test and ROM address per tank, disc test per bullet
   always_comb begin
      in_tank_d  = '0;
      rom_addr_d = '0;
      bul_d      = '0;
      dx_c       = '0;
      dy_c       = '0;
      sq_c       = '0;
      for (int unsigned j = 0; j < NUM_TANKS; j++) begin
         dx_c = sdiff(bus.DrawX, bus.TankX[j*COORD_W +: COORD_W]);
         dy_c = sdiff(bus.DrawY, bus.TankY[j*COORD_W +: COORD_W]);
         if (!dx_c[DW-1] && !dy_c[DW-1] &&
             ($unsigned(dx_c) < DW'(TANK_W)) && ($unsigned(dy_c) < DW'(TANK_H))) begin
            in_tank_d[j] = 1'b1;
            rom_addr_d[j*ADDR_W +: ADDR_W] =
               ADDR_W'(32'($unsigned(dy_c)) * TANK_W + 32'($unsigned(dx_c)));
         end
      end
      for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
         dx_c = sdiff(bus.DrawX, bus.BulletX[i*COORD_W +: COORD_W]);
         dy_c = sdiff(bus.DrawY, bus.BulletY[i*COORD_W +: COORD_W]);
         sq_c = SQW'(dx_c) * SQW'(dx_c) + SQW'(dy_c) * SQW'(dy_c);
         bul_d[i] = bus.bullet_active[i] && (sq_c <= R_SQ);
      end
   end

   // Stage 3 priority mux and this pixel's collision bits
   always_comb begin
      rgb_d  = '0;
      hits_d = '0;
      bg_c   = {1'b0, 7'h7F - s3_xh_q};
      if (s3_valid_q) begin
         case (s3_mode_q)
            2'b00: begin
               rgb_d = {8'h00, bg_c, 8'h00};
               for (int j = int'(NUM_TANKS) - 1; j >= 0; j--) begin
                  if (s3_opaque_q[j]) rgb_d = s3_col_q[j*CW +: CW];
               end
            end
            2'b01: begin
               rgb_d = {bg_c, 16'h0000};
               for (int unsigned j = 0; j < NUM_TANKS; j++) begin
                  if (s3_opaque_q[j]) rgb_d = s3_col_q[j*CW +: CW];
               end
               for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
                  if (s3_bul_q[i]) rgb_d = (i % 2 == 0) ? 24'hFFFF00 : 24'hFF00FF;
               end
               for (int unsigned j = 0; j < NUM_TANKS; j++) begin
                  for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
                     hits_d[j*NUM_BULLETS + i] = s3_bul_q[i] && s3_opaque_q[j];
                  end
               end
            end
            default: rgb_d = {bg_c, 16'h0000};
         endcase
      end
   end

   // Pipeline, output and collision registers
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         s1_valid_q   <= 1'b0;
         s1_fs_q      <= 1'b0;
         s1_mode_q    <= '0;
         s1_xh_q      <= '0;
         s1_in_tank_q <= '0;
         s1_bul_q     <= '0;
         rom_addr_q   <= '0;
         s2_valid_q   <= 1'b0;
         s2_fs_q      <= 1'b0;
         s2_mode_q    <= '0;
         s2_xh_q      <= '0;
         s2_in_tank_q <= '0;
         s2_bul_q     <= '0;
         s2_idx_q     <= '0;
         s3_valid_q   <= 1'b0;
         s3_fs_q      <= 1'b0;
         s3_mode_q    <= '0;
         s3_xh_q      <= '0;
         s3_opaque_q  <= '0;
         s3_bul_q     <= '0;
         s3_col_q     <= '0;
         rgb_q        <= '0;
         pix_valid_q  <= 1'b0;
         acc_q        <= '0;
         hit_q        <= '0;
      end else begin
         s1_valid_q   <= bus.pix_valid_in;
         s1_fs_q      <= bus.frame_start;
         s1_mode_q    <= bus.mode;
         s1_xh_q      <= bus.DrawX[9:3];
         s1_in_tank_q <= in_tank_d;
         s1_bul_q     <= bul_d;
         rom_addr_q   <= rom_addr_d;

         s2_valid_q   <= s1_valid_q;
         s2_fs_q      <= s1_fs_q;
         s2_mode_q    <= s1_mode_q;
         s2_xh_q      <= s1_xh_q;
         s2_in_tank_q <= s1_in_tank_q;
         s2_bul_q     <= s1_bul_q;
         s2_idx_q     <= bus.tank_rom_idx;

         s3_valid_q   <= s2_valid_q;
         s3_fs_q      <= s2_fs_q;
         s3_mode_q    <= s2_mode_q;
         s3_xh_q      <= s2_xh_q;
         s3_bul_q     <= s2_bul_q;
         for (int unsigned j = 0; j < NUM_TANKS; j++) begin
            s3_opaque_q[j] <= s2_in_tank_q[j] &&
                              (s2_idx_q[j*IDX_W +: IDX_W] != IDX_W'(TRANSP_IDX));
            s3_col_q[j*CW +: CW] <= pal_q[s2_idx_q[j*IDX_W +: IDX_W]];
         end

         rgb_q       <= rgb_d;
         pix_valid_q <= s3_valid_q;
         if (s3_fs_q) begin
            hit_q <= acc_q;
            acc_q <= hits_d;
         end else begin
            acc_q <= acc_q | hits_d;
         end
      end
   end

   // Palette: write lands at the edge, so a same-edge read still gets the old entry
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int unsigned k = 0; k < PAL_N; k++) pal_q[k] <= '0;
      end else if (bus.pal_we) begin
         pal_q[bus.pal_waddr] <= bus.pal_wdata;
      end
   end

   assign bus.tank_rom_addr = rom_addr_q;
   assign bus.Red           = rgb_q[23:16];
   assign bus.Green         = rgb_q[15:8];
   assign bus.Blue          = rgb_q[7:0];
   assign bus.pix_valid_out = pix_valid_q;
   assign bus.hit_flags     = hit_q;

endmodule

// File: tb/tb_tank_sprite_compositor.sv
// Bench for tank_sprite_compositor: directed scenarios plus random pixels vs a behavioural model.
module tb_tank_sprite_compositor;
   localparam int NT = 2;
   localparam int NB = 2;

   logic Clk = 1'b0;
   logic Reset = 1'b0;

   tank_sprite_compositor_if bus ();
   tank_sprite_compositor dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   always #5 Clk = ~Clk;

   // Sprite ROMs: data follows the registered address within the same cycle
   logic [3:0] rom_tbl [NT][4096];
   for (genvar g = 0; g < NT; g++) begin : g_rom
      assign bus.tank_rom_idx[g*4 +: 4] = rom_tbl[g][bus.tank_rom_addr[g*16 +: 12]];
   end

   typedef struct {
      bit          v;
      logic [23:0] rgb;
      logic [3:0]  hit;
   } exp_t;

   // Stimulus state
   int          px, py, tx[NT], ty[NT], bxp[NB], byp[NB];
   bit          pv, pfs, pwe;
   logic [1:0]  pmode;
   logic [NB-1:0] pact;
   logic [3:0]  pwa;
   logic [23:0] pwd;

   // Model state
   logic [23:0] pal_m [16];
   logic [3:0]  acc_m, hit_m;
   int          exp_addr [NT];
   exp_t        q[$];
   int          errors, checks;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      bus.pix_valid_in  = pv;
      bus.DrawX         = 10'(px);
      bus.DrawY         = 10'(py);
      bus.frame_start   = pfs;
      bus.mode          = pmode;
      for (int j = 0; j < NT; j++) begin
         bus.TankX[j*10 +: 10] = 10'(tx[j]);
         bus.TankY[j*10 +: 10] = 10'(ty[j]);
      end
      for (int i = 0; i < NB; i++) begin
         bus.BulletX[i*10 +: 10] = 10'(bxp[i]);
         bus.BulletY[i*10 +: 10] = 10'(byp[i]);
      end
      bus.bullet_active = pact;
      bus.pal_we        = pwe;
      bus.pal_waddr     = pwa;
      bus.pal_wdata     = pwd;
   endtask

   // Expected result of the current stimulus pixel, straight from the drawing rules
   task automatic model(output exp_t e);
      int dx, dy, bg;
      bit in_t;
      bit opq [NT];
      bit bl [NB];
      logic [23:0] col [NT];
      logic [3:0] idx, hits;
      for (int j = 0; j < NT; j++) begin
         dx = px - tx[j];
         dy = py - ty[j];
         in_t = (dx >= 0) && (dx < 70) && (dy >= 0) && (dy < 50);
         exp_addr[j] = in_t ? dy * 70 + dx : 0;
         idx = rom_tbl[j][exp_addr[j]];
         opq[j] = in_t && (idx != 4'd0);
         col[j] = pal_m[idx];
      end
      for (int i = 0; i < NB; i++) begin
         dx = px - bxp[i];
         dy = py - byp[i];
         bl[i] = pact[i] && (dx * dx + dy * dy <= 16);
      end
      bg = 127 - px / 8;
      e.v = pv;
      e.rgb = 24'h0;
      if (pv) begin
         if (pmode == 2'd0) begin
            e.rgb = 24'(bg) << 8;
            for (int j = NT - 1; j >= 0; j--) if (opq[j]) e.rgb = col[j];
         end else if (pmode == 2'd1) begin
            e.rgb = 24'(bg) << 16;
            for (int j = 0; j < NT; j++) if (opq[j]) e.rgb = col[j];
            for (int i = 0; i < NB; i++) if (bl[i]) e.rgb = (i % 2 == 0) ? 24'hFFFF00 : 24'hFF00FF;
         end else begin
            e.rgb = 24'(bg) << 16;
         end
      end
      hits = 4'h0;
      if (pv && pmode == 2'd1)
         for (int j = 0; j < NT; j++)
            for (int i = 0; i < NB; i++)
               if (bl[i] && opq[j]) hits[j*NB + i] = 1'b1;
      if (pfs) begin
         hit_m = acc_m;
         acc_m = hits;
      end else begin
         acc_m = acc_m | hits;
      end
      e.hit = hit_m;
   endtask

   task automatic prefill();
      exp_t z;
      z.v = 1'b0;
      z.rgb = 24'h0;
      z.hit = 4'h0;
      for (int k = 0; k < 3; k++) q.push_back(z);
   endtask

   task automatic step();
      exp_t e, f;
      drive();
      model(e);
      q.push_back(e);
      @(posedge Clk);
      #1;
      chk("rom_addr0", 32'(bus.tank_rom_addr[15:0]), 32'(exp_addr[0]));
      chk("rom_addr1", 32'(bus.tank_rom_addr[31:16]), 32'(exp_addr[1]));
      f = q.pop_front();
      chk("pix_valid", 32'(bus.pix_valid_out), 32'(f.v));
      chk("rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'(f.rgb));
      chk("hit_flags", 32'(bus.hit_flags), 32'(f.hit));
   endtask

   task automatic idle(input int n);
      pv = 1'b0;
      pfs = 1'b0;
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic pal_write(input logic [3:0] a, input logic [23:0] d);
      pv = 1'b0;
      pfs = 1'b0;
      pwe = 1'b1;
      pwa = a;
      pwd = d;
      step();
      pal_m[a] = d;
      pwe = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(bus.pix_valid_out), 32'h0);
      chk({tag, "_rgb"}, 32'({bus.Red, bus.Green, bus.Blue}), 32'h0);
      chk({tag, "_hit"}, 32'(bus.hit_flags), 32'h0);
      chk({tag, "_addr"}, bus.tank_rom_addr, 32'h0);
   endtask

   task automatic random_steps(input int n);
      int sel, k, m;
      for (int s = 0; s < n; s++) begin
         if (s % 64 == 0) begin
            for (int j = 0; j < NT; j++) begin
               tx[j] = int'($urandom_range(10, 300));
               ty[j] = int'($urandom_range(10, 200));
            end
            for (int i = 0; i < NB; i++) begin
               bxp[i] = tx[i] + int'($urandom_range(0, 70));
               byp[i] = ty[i] + int'($urandom_range(0, 50));
            end
         end
         sel = int'($urandom_range(0, 3));
         if (sel < 2) begin
            px = bxp[sel] + int'($urandom_range(0, 10)) - 5;
            py = byp[sel] + int'($urandom_range(0, 10)) - 5;
         end else if (sel == 2) begin
            k = int'($urandom_range(0, NT - 1));
            px = tx[k] + int'($urandom_range(0, 74)) - 2;
            py = ty[k] + int'($urandom_range(0, 54)) - 2;
         end else begin
            px = int'($urandom_range(0, 1023));
            py = int'($urandom_range(0, 1023));
         end
         pv = ($urandom_range(0, 9) != 0);
         m = int'($urandom_range(0, 5));
         pmode = (m == 0) ? 2'd0 : (m <= 3) ? 2'd1 : (m == 4) ? 2'd2 : 2'd3;
         pact = 2'($urandom_range(0, 3));
         pfs = (s % 50 == 7);
         step();
      end
      pfs = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      pv = 1'b0; pfs = 1'b0; pwe = 1'b0; pmode = 2'd0; pact = '0;
      pwa = '0; pwd = '0; px = 0; py = 0;
      for (int j = 0; j < NT; j++) begin tx[j] = 600; ty[j] = 400; end
      for (int i = 0; i < NB; i++) begin bxp[i] = 900; byp[i] = 900; end
      for (int j = 0; j < NT; j++)
         for (int a = 0; a < 4096; a++) rom_tbl[j][a] = 4'($urandom);
      for (int k = 0; k < 16; k++) pal_m[k] = 24'h0;
      acc_m = 4'h0;
      hit_m = 4'h0;
      drive();

      // Reset state
      Reset = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk_all_zero("reset");
      Reset = 1'b1;
      prefill();

      // First pixel (0,0) in select mode: green gradient 7F
      pv = 1'b1; px = 0; py = 0; pmode = 2'd0;
      step();
      idle(3);

      // Single tank, opaque index 3
      rom_tbl[0][360] = 4'd3;
      rom_tbl[1][360] = 4'd5;
      tx[0] = 100; ty[0] = 100;
      pal_write(4'd3, 24'h123456);
      pal_write(4'd5, 24'hABCDEF);
      pal_write(4'd7, 24'h0F1E2D);
      pv = 1'b1; px = 110; py = 105; pmode = 2'd0;
      step();
      idle(3);

      // Transparent sprite pixel in fight mode: red gradient 72
      rom_tbl[0][360] = 4'd0;
      pv = 1'b1; pmode = 2'd1;
      step();
      idle(3);

      // Two overlapping tanks, then bullet1 on / off its radius boundary
      rom_tbl[0][360] = 4'd3;
      tx[1] = 100; ty[1] = 100;
      pv = 1'b1; pmode = 2'd0; step();
      pmode = 2'd1; step();
      pact = 2'b10; bxp[1] = 106; byp[1] = 105; step();
      bxp[1] = 107; byp[1] = 102; step();
      idle(3);

      // Sprite window edges: last column/row in, one past out, one before out
      rom_tbl[0][49*70 + 69] = 4'd7;
      pact = 2'b00; pmode = 2'd0; pv = 1'b1;
      px = 169; py = 149; step();
      px = 170; py = 149; step();
      px = 169; py = 150; step();
      px = 99;  py = 105; step();
      idle(3);

      // Collision flags: one overlapping pixel in a frame, then an empty frame
      tx[0] = 600; ty[0] = 400;
      pmode = 2'd1; pact = 2'b01;
      bxp[0] = 110; byp[0] = 105; bxp[1] = 900; byp[1] = 900;
      pv = 1'b1; pfs = 1'b1; px = 0; py = 0; step();
      pfs = 1'b0; px = 110; py = 105; step();
      px = 300; py = 300; step();
      pfs = 1'b1; px = 0; py = 0; step();
      idle(3);
      chk("hit_after_frame", 32'(bus.hit_flags), 32'h4);
      pv = 1'b1; pfs = 1'b1; px = 0; py = 0; step();
      pfs = 1'b0; px = 300; py = 300; step();
      pfs = 1'b1; px = 0; py = 0; step();
      idle(3);
      chk("hit_cleared", 32'(bus.hit_flags), 32'h0);
      pact = 2'b00;
      pv = 1'b1; pfs = 1'b1; px = 0; py = 0; step();
      pfs = 1'b0; px = 110; py = 105; step();
      pfs = 1'b1; px = 0; py = 0; step();
      idle(3);
      chk("hit_inactive", 32'(bus.hit_flags), 32'h0);

      // Palette write on the same edge as a pixel's palette read
      tx[0] = 100; ty[0] = 100; pmode = 2'd0;
      pv = 1'b1; px = 110; py = 105; step();
      pal_m[3] = 24'h00CAFE; step();
      pwe = 1'b1; pwa = 4'd3; pwd = 24'h00CAFE; step();
      pwe = 1'b0;
      idle(3);

      // Random scenes with a random palette
      for (int k = 0; k < 16; k++) pal_write(4'(k), 24'($urandom));
      random_steps(400);

      // Asynchronous reset with pixels in flight
      pv = 1'b1; pmode = 2'd1; px = 120; py = 110;
      step();
      step();
      Reset = 1'b0;
      #1;
      chk_all_zero("midreset");
      q.delete();
      acc_m = 4'h0;
      hit_m = 4'h0;
      for (int k = 0; k < 16; k++) pal_m[k] = 24'h0;
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      prefill();
      random_steps(60);
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tank_sprite_compositor.md
Name: tank_sprite_compositor

Overview:
- Pipelined, parametrised pixel compositor for the tank game's VGA path.
- Draws NUM_TANKS sprite tanks (external colour-index ROMs) and NUM_BULLETS round bullets over a gradient background, under a game-mode select.
- Holds a writable colour palette and per-frame bullet-to-tank pixel-collision flags.
- Sits between the VGA controller (DrawX/DrawY) and the video DAC outputs.

Parameters:
- NUM_TANKS, 2, number of tank sprites.
- NUM_BULLETS, 2, number of bullets.
- COORD_W, 10, coordinate width.
- TANK_W, 70, sprite width in pixels.
- TANK_H, 50, sprite height in pixels.
- BULLET_R, 4, bullet radius in pixels.
- IDX_W, 4, colour-index width; the palette has 2^IDX_W entries.
- ADDR_W, 16, sprite ROM address width.
- TRANSP_IDX, 0, colour index treated as transparent.

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  asynchronous, active-low reset.
- pix_valid_in  in  1  DrawX/DrawY valid this cycle.
- DrawX, DrawY  in  COORD_W each  current pixel.
- frame_start  in  1  high with the first pixel of a frame.
- mode  in  2  00 select, 01 fight, 10/11 over.
- TankX, TankY  in  NUM_TANKS*COORD_W each  top-left corners; tank j at [j*COORD_W +: COORD_W].
- BulletX, BulletY  in  NUM_BULLETS*COORD_W each  bullet centres.
- bullet_active  in  NUM_BULLETS  bullet i is drawn and tested only when its bit is 1.
- tank_rom_addr  out  NUM_TANKS*ADDR_W  registered sprite ROM addresses.
- tank_rom_idx  in  NUM_TANKS*IDX_W  ROM data, returned exactly 1 cycle after the address.
- pal_we  in  1  palette write strobe.
- pal_waddr  in  IDX_W  palette write address.
- pal_wdata  in  24  palette write data, {R,G,B}.
- Red, Green, Blue  out  8 each  registered pixel colour.
- pix_valid_out  out  1  RGB valid.
- hit_flags  out  NUM_TANKS*NUM_BULLETS  previous frame's collisions; bit j*NUM_BULLETS+i = bullet i touched tank j.

Behaviour:
- Reset (Reset=0, asynchronous): all pipeline registers, RGB, pix_valid_out, tank_rom_addr, hit_flags, the collision accumulator and every palette entry go to 0.
- Pipeline, fixed latency 3. A pixel sampled at edge k appears on RGB/pix_valid_out after edge k+3. pix_valid_in, DrawX, frame_start and mode travel with the pixel. There are no stalls.
- Stage 1: registers the following.
  - dx = DrawX-TankX_j and dy = DrawY-TankY_j, as signed COORD_W+1 values.
  - in_tank_j = 0<=dx<TANK_W && 0<=dy<TANK_H (strict upper bound).
  - tank_rom_addr_j = dy*TANK_W+dx, truncated to ADDR_W, or 0 when not in_tank_j.
  - bul_i = bullet_active_i && (bx²+by² <= BULLET_R²), computed on signed deltas with no overflow.
- Stage 2: captures tank_rom_idx_j. opaque_j = in_tank_j && idx_j != TRANSP_IDX. Palette reads for each tank's index are registered.
- Palette: a write at edge w is visible to reads issued after edge w. A read in the same cycle as the write returns the old value.
- Stage 3 priority mux, registered:
  - mode 00: lowest-index opaque tank wins, else background {00, 7F-DrawX[9:3], 00}. Bullets are not drawn.
  - mode 01: highest-index active bullet wins. Even bullets are FFFF00, odd bullets FF00FF. Next, the highest-index opaque tank. Otherwise background {7F-DrawX[9:3], 00, 00}.
  - mode 1x: background {7F-DrawX[9:3], 00, 00} only.
  - When pix_valid is low at stage 3, RGB = 0.
- Collision accumulator acc, evaluated at stage 3:
  - In mode 01 with pix valid, set acc[j*NUM_BULLETS+i] when bul_i && opaque_j.
  - When the stage-3 pixel carries frame_start: hit_flags <= acc, and acc <= that pixel's own hit bits only (the old acc is discarded).
  - hit_flags is therefore stable for a full frame and reports the frame that just ended.
  - Overlaps hidden under a higher-priority bullet still count.
- mode changes mid-frame take effect per pixel as the pixel travels down the pipeline.
- Reset mid-frame: the pipeline empties. pix_valid_out is 0 for at least 3 cycles after release.

Test Plan:
- Reset, then drive pixel (0,0) valid with mode=00 -> pix_valid_out=1 on the 3rd edge, RGB=00,7F,00; every output is 0 before that.
- Tank0 at (100,100). ROM model returns idx=3 at address 5*70+10, with palette[3]=123456. Drive pixel (110,105) in mode 00 -> tank_rom_addr_0=360 one edge later, and RGB=12,34,56 at latency 3.
- Same tank and pixel with ROM idx=TRANSP_IDX, mode 01, DrawX=110 -> background RGB=(7F-0D),00,00 = 72,00,00.
- Tanks 0 and 1 both opaque at the pixel -> mode 00 shows tank0's colour, mode 01 shows tank1's colour. Add active bullet1 within radius 4 (dx=4, dy=0) -> FF00FF. At dx=3, dy=3 (18>16) -> tank1 colour.
- Bullet0 over opaque tank1 for one pixel in mode 01, then frame_start -> hit_flags=0100 (bit 1*2+0) after frame_start reaches stage 3; it clears to 0 after the next frame with no overlap. With bullet_active=0, no bit is set.
- Palette write of index 3 in the same cycle as a stage-2 read of index 3 -> the pixel shows the old value and the next pixel shows the new one.
